// File: rtl/nx_fifo_pkg.sv
// rtl/nx_fifo_pkg.sv - shared widths and per-channel flag state for the multi-channel FIFO controller
package nx_fifo_pkg;

  function automatic int uw_f(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int pw_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int aw_f(input int channels, input int depth);
    return ((channels * depth) > 1) ? $clog2(channels * depth) : 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic aempty;
    logic afull;
  } ch_flags_t;

endpackage

// File: rtl/nx_fifo_ctrl_ch.sv
// rtl/nx_fifo_ctrl_ch.sv - one channel's pointers, occupancy, watermark flags and sticky errors
module nx_fifo_ctrl_ch
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH            = 6,
  parameter int AFULL_LEVEL      = DEPTH - 1,
  parameter int AEMPTY_LEVEL     = 1,
  parameter int OVERFLOW_ASSERT  = 1,
  parameter int UNDERFLOW_ASSERT = 1,
  localparam int UW = uw_f(DEPTH),
  localparam int PW = pw_f(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wen,
  input  logic          i_ren,
  input  logic          i_clear,
  input  logic          i_err_clr,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_aempty,
  output logic          o_afull,
  output logic [UW-1:0] o_used,
  output logic [UW-1:0] o_free,
  output logic [PW-1:0] o_rptr,
  output logic [PW-1:0] o_wptr,
  output logic          o_ovf,
  output logic          o_udf,
  output logic          o_ovf_sticky,
  output logic          o_udf_sticky
);

  ch_flags_t     r_flags;
  logic [UW-1:0] r_used;
  logic [UW-1:0] r_free;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic          r_ovf_sticky;
  logic          r_udf_sticky;

  logic          w_push;
  logic          w_pop;
  logic          w_ovf;
  logic          w_udf;
  logic [UW-1:0] w_used_nxt;
  logic [PW-1:0] w_rptr_inc;
  logic [PW-1:0] w_wptr_inc;

  // Requests are judged only against registered flags, so a same-cycle pop never frees room for a push.
  assign w_push = i_wen && !r_flags.full;
  assign w_pop  = i_ren && !r_flags.empty;
  assign w_ovf  = i_wen && r_flags.full;
  assign w_udf  = i_ren && r_flags.empty;

  assign w_rptr_inc = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
  assign w_wptr_inc = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);

  always_comb begin
    w_used_nxt = r_used;
    if (i_clear)
      w_used_nxt = '0;
    else if (w_push && !w_pop)
      w_used_nxt = r_used + UW'(1);
    else if (w_pop && !w_push)
      w_used_nxt = r_used - UW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_used         <= '0;
      r_free         <= UW'(DEPTH);
      r_rptr         <= '0;
      r_wptr         <= '0;
      r_flags.empty  <= 1'b1;
      r_flags.full   <= 1'b0;
      r_flags.aempty <= 1'b1;
      r_flags.afull  <= (AFULL_LEVEL == 0);
      r_ovf_sticky   <= 1'b0;
      r_udf_sticky   <= 1'b0;
    end else begin
      r_used <= w_used_nxt;
      r_free <= UW'(DEPTH) - w_used_nxt;
      if (i_clear) begin
        r_rptr <= '0;
        r_wptr <= '0;
      end else begin
        if (w_pop)
          r_rptr <= w_rptr_inc;
        if (w_push)
          r_wptr <= w_wptr_inc;
      end
      // Watermarks track the next count so they line up with o_used.
      r_flags.empty  <= (w_used_nxt == '0);
      r_flags.full   <= (w_used_nxt == UW'(DEPTH));
      r_flags.aempty <= (w_used_nxt <= UW'(AEMPTY_LEVEL));
      r_flags.afull  <= (w_used_nxt >= UW'(AFULL_LEVEL));
      if (w_ovf)
        r_ovf_sticky <= 1'b1;
      else if (i_err_clr || i_clear)
        r_ovf_sticky <= 1'b0;
      if (w_udf)
        r_udf_sticky <= 1'b1;
      else if (i_err_clr || i_clear)
        r_udf_sticky <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (OVERFLOW_ASSERT != 0 && rst_n)
      assert (!w_ovf) else $error("nx_fifo_ctrl_ch: push into full channel");
    if (UNDERFLOW_ASSERT != 0 && rst_n)
      assert (!w_udf) else $error("nx_fifo_ctrl_ch: pop from empty channel");
  end

  assign o_empty      = r_flags.empty;
  assign o_full       = r_flags.full;
  assign o_aempty     = r_flags.aempty;
  assign o_afull      = r_flags.afull;
  assign o_used       = r_used;
  assign o_free       = r_free;
  assign o_rptr       = r_rptr;
  assign o_wptr       = r_wptr;
  assign o_ovf        = w_ovf;
  assign o_udf        = w_udf;
  assign o_ovf_sticky = r_ovf_sticky;
  assign o_udf_sticky = r_udf_sticky;

endmodule

// File: rtl/nx_fifo_ctrl_mc.sv
// rtl/nx_fifo_ctrl_mc.sv - multi-channel FIFO controller carving independent queues out of one shared RAM
module nx_fifo_ctrl_mc
  import nx_fifo_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int DEPTH            = 6,
  parameter int AFULL_LEVEL      = DEPTH - 1,
  parameter int AEMPTY_LEVEL     = 1,
  parameter int OVERFLOW_ASSERT  = 1,
  parameter int UNDERFLOW_ASSERT = 1,
  localparam int UW = uw_f(DEPTH),
  localparam int PW = pw_f(DEPTH),
  localparam int AW = aw_f(CHANNELS, DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CHANNELS-1:0]    wen,
  input  logic [CHANNELS-1:0]    ren,
  input  logic [CHANNELS-1:0]    clear,
  input  logic [CHANNELS-1:0]    err_clr,
  output logic [CHANNELS-1:0]    empty,
  output logic [CHANNELS-1:0]    full,
  output logic [CHANNELS-1:0]    almost_empty,
  output logic [CHANNELS-1:0]    almost_full,
  output logic [CHANNELS*UW-1:0] used_slots,
  output logic [CHANNELS*UW-1:0] free_slots,
  output logic [CHANNELS*AW-1:0] raddr,
  output logic [CHANNELS*AW-1:0] waddr,
  output logic [CHANNELS-1:0]    overflow,
  output logic [CHANNELS-1:0]    underflow,
  output logic [CHANNELS-1:0]    ovf_sticky,
  output logic [CHANNELS-1:0]    udf_sticky
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [AW-1:0] BASE = AW'(c * DEPTH);

    logic [PW-1:0] w_rptr;
    logic [PW-1:0] w_wptr;

    nx_fifo_ctrl_ch #(
      .DEPTH            (DEPTH),
      .AFULL_LEVEL      (AFULL_LEVEL),
      .AEMPTY_LEVEL     (AEMPTY_LEVEL),
      .OVERFLOW_ASSERT  (OVERFLOW_ASSERT),
      .UNDERFLOW_ASSERT (UNDERFLOW_ASSERT)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_wen        (wen[c]),
      .i_ren        (ren[c]),
      .i_clear      (clear[c]),
      .i_err_clr    (err_clr[c]),
      .o_empty      (empty[c]),
      .o_full       (full[c]),
      .o_aempty     (almost_empty[c]),
      .o_afull      (almost_full[c]),
      .o_used       (used_slots[c*UW +: UW]),
      .o_free       (free_slots[c*UW +: UW]),
      .o_rptr       (w_rptr),
      .o_wptr       (w_wptr),
      .o_ovf        (overflow[c]),
      .o_udf        (underflow[c]),
      .o_ovf_sticky (ovf_sticky[c]),
      .o_udf_sticky (udf_sticky[c])
    );

    // Each channel owns the contiguous RAM window [c*DEPTH, c*DEPTH+DEPTH-1].
    assign raddr[c*AW +: AW] = BASE + AW'(w_rptr);
    assign waddr[c*AW +: AW] = BASE + AW'(w_wptr);
  end

endmodule

// File: tb/tb_nx_fifo_ctrl_mc.sv
// tb/tb_nx_fifo_ctrl_mc.sv - randomized and directed check of nx_fifo_ctrl_mc against an occupancy model
module tb_nx_fifo_ctrl_mc;
  import nx_fifo_pkg::*;

  localparam int CH = 4;
  localparam int D  = 6;
  localparam int AF = 5;
  localparam int AE = 1;
  localparam int UW = uw_f(D);
  localparam int AW = aw_f(CH, D);

  logic clk = 1'b0;
  logic rst_n;
  logic [CH-1:0] wen, ren, clear, err_clr;
  logic [CH-1:0] empty, full, almost_empty, almost_full;
  logic [CH*UW-1:0] used_slots, free_slots;
  logic [CH*AW-1:0] raddr, waddr;
  logic [CH-1:0] overflow, underflow, ovf_sticky, udf_sticky;

  nx_fifo_ctrl_mc #(
    .CHANNELS(CH), .DEPTH(D), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE),
    .OVERFLOW_ASSERT(0), .UNDERFLOW_ASSERT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .clear(clear), .err_clr(err_clr),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .used_slots(used_slots), .free_slots(free_slots), .raddr(raddr), .waddr(waddr),
    .overflow(overflow), .underflow(underflow), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: occupancy and write index per channel; read index follows as (wr - used) mod D.
  int m_used[CH];
  int m_wr[CH];
  bit m_ovs[CH];
  bit m_uds[CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_used[c] = 0; m_wr[c] = 0; m_ovs[c] = 0; m_uds[c] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < CH; c++) begin
      int rd;
      rd = (m_wr[c] - m_used[c] + D) % D;
      chk($sformatf("%s used[%0d]", tag, c), 32'(used_slots[c*UW +: UW]), m_used[c]);
      chk($sformatf("%s free[%0d]", tag, c), 32'(free_slots[c*UW +: UW]), D - m_used[c]);
      chk($sformatf("%s empty[%0d]", tag, c), 32'(empty[c]), 32'(m_used[c] == 0));
      chk($sformatf("%s full[%0d]", tag, c), 32'(full[c]), 32'(m_used[c] == D));
      chk($sformatf("%s aempty[%0d]", tag, c), 32'(almost_empty[c]), 32'(m_used[c] <= AE));
      chk($sformatf("%s afull[%0d]", tag, c), 32'(almost_full[c]), 32'(m_used[c] >= AF));
      chk($sformatf("%s raddr[%0d]", tag, c), 32'(raddr[c*AW +: AW]), c * D + rd);
      chk($sformatf("%s waddr[%0d]", tag, c), 32'(waddr[c*AW +: AW]), c * D + m_wr[c]);
      chk($sformatf("%s ovf_sticky[%0d]", tag, c), 32'(ovf_sticky[c]), 32'(m_ovs[c]));
      chk($sformatf("%s udf_sticky[%0d]", tag, c), 32'(udf_sticky[c]), 32'(m_uds[c]));
    end
  endtask

  task automatic step(input logic [CH-1:0] w, input logic [CH-1:0] r,
                      input logic [CH-1:0] cl, input logic [CH-1:0] ec, input string tag);
    bit eo[CH];
    bit eu[CH];
    wen = w; ren = r; clear = cl; err_clr = ec;
    #1;
    for (int c = 0; c < CH; c++) begin
      eo[c] = w[c] && (m_used[c] == D);
      eu[c] = r[c] && (m_used[c] == 0);
      chk($sformatf("%s overflow[%0d]", tag, c), 32'(overflow[c]), 32'(eo[c]));
      chk($sformatf("%s underflow[%0d]", tag, c), 32'(underflow[c]), 32'(eu[c]));
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      if (cl[c]) begin
        m_used[c] = 0;
        m_wr[c]   = 0;
      end else begin
        bit push, pop;
        push = w[c] && (m_used[c] < D);
        pop  = r[c] && (m_used[c] > 0);
        m_used[c] = m_used[c] + int'(push) - int'(pop);
        if (push) m_wr[c] = (m_wr[c] + 1) % D;
      end
      if (eo[c]) m_ovs[c] = 1; else if (ec[c] || cl[c]) m_ovs[c] = 0;
      if (eu[c]) m_uds[c] = 1; else if (ec[c] || cl[c]) m_uds[c] = 0;
    end
    wen = '0; ren = '0; clear = '0; err_clr = '0;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    wen = '0; ren = '0; clear = '0; err_clr = '0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset overflow", 32'(overflow), 0);
    chk("reset underflow", 32'(underflow), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) step(4'b0100, 4'b0000, 4'b0000, 4'b0000, "tp1 fill ch2");
    chk("tp1 full2", 32'(full[2]), 1);
    chk("tp1 waddr2 wrap", 32'(waddr[2*AW +: AW]), 12);

    for (int i = 0; i < 6; i++) step(4'b0010, 4'b0000, 4'b0000, 4'b0000, "tp2 fill ch1");
    step(4'b0010, 4'b0010, 4'b0000, 4'b0000, "tp2 full wen+ren");
    chk("tp2 ovf_sticky1", 32'(ovf_sticky[1]), 1);
    chk("tp2 used1", 32'(used_slots[1*UW +: UW]), 5);
    chk("tp2 raddr1", 32'(raddr[1*AW +: AW]), 7);

    step(4'b0001, 4'b0001, 4'b0000, 4'b0000, "tp3 empty wen+ren");
    chk("tp3 used0", 32'(used_slots[0 +: UW]), 1);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0001, "tp3 err_clr");
    chk("tp3 udf_sticky0", 32'(udf_sticky[0]), 0);

    for (int i = 0; i < 5; i++) step(4'b1000, 4'b0000, 4'b0000, 4'b0000, "tp4 push ch3");
    chk("tp4 afull3", 32'(almost_full[3]), 1);
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b1000, 4'b0000, 4'b0000, "tp4 pop ch3");
    chk("tp4 aempty3", 32'(almost_empty[3]), 1);

    step(4'b0000, 4'b0100, 4'b0000, 4'b0000, "tp5 pop ch2");
    step(4'b0000, 4'b0100, 4'b0000, 4'b0000, "tp5 pop ch2");
    step(4'b0100, 4'b0000, 4'b0100, 4'b0000, "tp5 clear+wen");
    chk("tp5 raddr2", 32'(raddr[2*AW +: AW]), 12);
    chk("tp5 waddr2", 32'(waddr[2*AW +: AW]), 12);

    for (int i = 0; i < 400; i++) begin
      logic [CH-1:0] w, r, cl, ec;
      if (i < 130) begin
        w = CH'($urandom); r = CH'($urandom) & CH'($urandom);
      end else if (i < 260) begin
        w = CH'($urandom) & CH'($urandom); r = CH'($urandom);
      end else begin
        w = CH'($urandom); r = CH'($urandom);
      end
      cl = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      ec = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
      step(w, r, cl, ec, $sformatf("rand%0d", i));
    end

    for (int i = 0; i < 8; i++) step(CH'($urandom), CH'($urandom) & CH'($urandom), '0, '0, "pre-rst");
    wen = CH'($urandom); ren = CH'($urandom);
    #1;
    rst_n = 1'b0;
    #1;
    wen = '0; ren = '0;
    model_reset();
    #1;
    check_all("async rst");
    chk("async rst overflow", 32'(overflow), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step({CH{1'b1}}, '0, '0, '0, "post-rst push");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
